nibble_serial_adder: RTL and testbench

- Multi-precision adder/subtractor that processes WIDTH-bit operands one 4-bit nibble per clock, least significant nibble first.
- Each nibble step is a 4-bit ripple-carry add: 4-bit A, 4-bit B and 1-bit Cin produce a 4-bit S and a Cout. The team's 4-bit adder stage may be instantiated for this step.
- The nibble carry is held in a register between cycles.
- Sits in front of consumers that need wide sums. Uses a valid/ready handshake on both the input side and the output side.

---
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-precision add/subtract, one 4-bit nibble per clock, LSB nibble first
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        nib_res;

    // Current nibble slice and its 4-bit ripple add with the held carry
    always_comb begin
        a_nib   = op_a_q[4*idx_q +: 4];
        b_nib   = op_b_q[4*idx_q +: 4];
        nib_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    end

    // Next-state and datapath updates; handshake outputs decode the registered state only
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = nib_res[3:0];
                carry_d             = nib_res[4];
                idx_d               = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_res[4];
                    // Signed overflow: operands agree in sign but the result sign differs
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (nib_res[3] != op_a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int passed;
    int total;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Present an operand for one edge; returns at edge+1 with in_valid low
    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vcin, input logic vsub);
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after acceptance until out_valid; bounded
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Reference: plain wide arithmetic on the whole operands
    task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic vsub,
                         output logic [W-1:0] s, output logic c, output logic o);
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = vsub ? ~vb : vb;
        full = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, vcin};
        s    = full[W-1:0];
        c    = full[W];
        o    = (va[W-1] == bb[W-1]) && (s[W-1] != va[W-1]);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ms;
        logic mc, mo;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        logic bp_ok;

        passed = 0;
        total  = 0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready outside DONE is ignored
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_ready_valid", 32'(out_valid), 32'd0);
        check("idle_out_ready_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            check($sformatf("vec%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            accept_result();
            check($sformatf("vec%0d_back_idle", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Backpressure: result held while new operands are offered
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            bp_ok = out_valid && !in_ready && sum == 16'h3333 && !cout && !ovf;
            check($sformatf("bp_hold%0d", i), 32'(bp_ok), 32'd1);
        end
        in_valid = 1'b0;
        accept_result();
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        check("bp_sum_kept_idle", 32'(sum), 32'h3333);

        // in_valid held high through DONE->IDLE: accepted on the first IDLE edge
        a = 16'h0100; b = 16'h0200; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("hold_valid_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_result(lat);
        check("hold_valid_latency", 32'(lat), 32'd4);
        check("hold_valid_sum", 32'(sum), 32'h0301);
        accept_result();

        // Reset mid-RUN with a pending carry, then a fresh operation
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_sum", 32'(sum), 32'd0);
        check("midrun_rst_flags", {29'd0, out_valid, in_ready, cout}, 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_valid", 32'(out_valid), 32'd0);
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_result(lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_sum", 32'(sum), 32'h0100);
        check("post_rst_cout", 32'(cout), 32'd0);
        accept_result();

        // Randomized against the wide-arithmetic model
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            model(ra, rb, rc, rs, ms, mc, mo);
            start_op(ra, rb, rc, rs);
            wait_result(lat);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("rnd%0d_result", i), {14'd0, sum, cout, ovf}, {14'd0, ms, mc, mo});
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            accept_result();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
